// File: rtl/square_motion.sv
// Playfield position producer: advances up to 16 bouncing obstacle squares one
// slot per clock after each frame tick, then moves the player from the buttons.
module square_motion #(
  parameter int          SQUARE_SIZE = 30,
  parameter int          H_RES       = 640,
  parameter int          V_RES       = 480,
  parameter int          MAIN_SPEED  = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         refresh_tick,
  input  logic         status,
  input  logic [5:0]   num_squares,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  output logic [659:0] position,
  output logic         busy,
  output logic         frame_done
);

  // state  | meaning
  // S_IDLE | waiting for a frame tick while the game is running
  // S_UPD  | advancing obstacle slot idx_q, one slot per clock
  // S_MAIN | moving the player square, then pulsing frame_done

  localparam logic [9:0] MAX_X  = 10'(H_RES - SQUARE_SIZE);
  localparam logic [9:0] MAX_Y  = 10'(V_RES - SQUARE_SIZE);
  localparam logic [9:0] MSPD   = 10'(MAIN_SPEED);
  localparam logic [9:0] PARK   = 10'd1023;
  localparam logic [9:0] INIT_X = 10'((H_RES - SQUARE_SIZE) / 2);
  localparam logic [9:0] INIT_Y = 10'((V_RES - SQUARE_SIZE) / 2);

  typedef enum logic [1:0] {S_IDLE, S_UPD, S_MAIN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  act_q, act_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [9:0]  px_q, px_d, py_q, py_d;

  logic [9:0]  x_q  [16];
  logic [9:0]  x_d  [16];
  logic [9:0]  y_q  [16];
  logic [9:0]  y_d  [16];
  logic        dx_q [16];
  logic        dx_d [16];
  logic        dy_q [16];
  logic        dy_d [16];
  logic [3:0]  sp_q [16];
  logic [3:0]  sp_d [16];
  logic        fl_q [16];
  logic        fl_d [16];

  // Returns {new_dir, new_pos}; the 11-bit sum keeps pos+speed from wrapping.
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                            input logic [3:0] spd, input logic [9:0] lim);
    logic [10:0] sum;
    sum = {1'b0, pos} + {7'd0, spd};
    if (dir) begin
      if (sum > {1'b0, lim}) step_axis = {1'b0, lim};
      else                   step_axis = {1'b1, sum[9:0]};
    end else begin
      if (pos < {6'd0, spd}) step_axis = {1'b1, 10'd0};
      else                   step_axis = {1'b0, pos - {6'd0, spd}};
    end
  endfunction

  logic [10:0] ax_x, ax_y;
  logic [9:0]  spawn_x;
  logic [10:0] py_sum, px_sum;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    act_d   = act_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    px_d    = px_q;
    py_d    = py_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sp_d    = sp_q;
    fl_d    = fl_q;
    ax_x    = step_axis(x_q[idx_q], dx_q[idx_q], sp_q[idx_q], MAX_X);
    ax_y    = step_axis(y_q[idx_q], dy_q[idx_q], sp_q[idx_q], MAX_Y);
    spawn_x = (lfsr_q[9:0] < MAX_X) ? lfsr_q[9:0] : lfsr_q[9:0] - MAX_X;
    py_sum  = {1'b0, py_q} + {1'b0, MSPD};
    px_sum  = {1'b0, px_q} + {1'b0, MSPD};

    case (state_q)
      S_IDLE: begin
        if (refresh_tick && status) begin
          state_d = S_UPD;
          idx_d   = 4'd0;
          busy_d  = 1'b1;
          act_d   = (num_squares > 6'd16) ? 5'd16 : num_squares[4:0];
        end
      end
      S_UPD: begin
        if ({1'b0, idx_q} >= act_q) begin
          x_d[idx_q]  = PARK;
          y_d[idx_q]  = PARK;
          dx_d[idx_q] = 1'b0;
          dy_d[idx_q] = 1'b0;
          sp_d[idx_q] = 4'd0;
          fl_d[idx_q] = 1'b0;
        end else if (!fl_q[idx_q]) begin
          x_d[idx_q]  = spawn_x;
          y_d[idx_q]  = 10'd0;
          dx_d[idx_q] = lfsr_q[10];
          dy_d[idx_q] = 1'b1;
          sp_d[idx_q] = 4'd1 + {2'b00, lfsr_q[12:11]};
          fl_d[idx_q] = 1'b1;
        end else begin
          x_d[idx_q]  = ax_x[9:0];
          dx_d[idx_q] = ax_x[10];
          y_d[idx_q]  = ax_y[9:0];
          dy_d[idx_q] = ax_y[10];
        end
        if (idx_q == 4'd15) state_d = S_MAIN;
        else                idx_d   = idx_q + 4'd1;
      end
      S_MAIN: begin
        if (btn_up && !btn_down)
          py_d = (py_q < MSPD) ? 10'd0 : py_q - MSPD;
        else if (btn_down && !btn_up)
          py_d = (py_sum > {1'b0, MAX_Y}) ? MAX_Y : py_sum[9:0];
        if (btn_left && !btn_right)
          px_d = (px_q < MSPD) ? 10'd0 : px_q - MSPD;
        else if (btn_right && !btn_left)
          px_d = (px_sum > {1'b0, MAX_X}) ? MAX_X : px_sum[9:0];
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      act_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      px_q    <= INIT_X;
      py_q    <= INIT_Y;
      for (int i = 0; i < 16; i++) begin
        x_q[i]  <= PARK;
        y_q[i]  <= PARK;
        dx_q[i] <= 1'b0;
        dy_q[i] <= 1'b0;
        sp_q[i] <= 4'd0;
        fl_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lfsr_q  <= lfsr_d;
      px_q    <= px_d;
      py_q    <= py_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sp_q    <= sp_d;
      fl_q    <= fl_d;
    end
  end

  always_comb begin
    position = '0;
    for (int i = 0; i < 16; i++) begin
      position[i*40 +: 10]    = x_q[i];
      position[i*40+10 +: 10] = y_q[i];
      position[i*40+20]       = dx_q[i];
      position[i*40+21]       = dy_q[i];
      position[i*40+22 +: 4]  = sp_q[i];
    end
    position[640 +: 10] = px_q;
    position[650 +: 10] = py_q;
  end

  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
